// File: rtl/biu_mmio_arb_if.sv
// biu_mmio_arb_if: core fetch/data, ITIM/DTIM and MMIO channel signals of the bus interface unit
interface biu_mmio_arb_if #(
    parameter int TIM_AW   = 12,
    parameter int NUM_MMIO = 2
);
    logic [31:0]            biu_i_iaddr;
    logic [31:0]            biu_o_idata;
    logic                   biu_i_dreq;
    logic [31:0]            biu_i_daddr;
    logic [3:0]             biu_i_dwmask;
    logic [31:0]            biu_i_dwdata;
    logic [31:0]            biu_o_drdata;
    logic                   biu_o_halt;
    logic                   biu_o_derr;
    logic [TIM_AW-1:0]      biu_o_itim_addr;
    logic [31:0]            biu_i_itim_rdata;
    logic [TIM_AW-1:0]      biu_o_dtim_addr;
    logic [3:0]             biu_o_dtim_wmask;
    logic [31:0]            biu_o_dtim_wdata;
    logic [31:0]            biu_i_dtim_rdata;
    logic [NUM_MMIO-1:0]    biu_o_mmio_req;
    logic [31:0]            biu_o_mmio_addr;
    logic [3:0]             biu_o_mmio_wmask;
    logic [31:0]            biu_o_mmio_wdata;
    logic [NUM_MMIO-1:0]    biu_i_mmio_ack;
    logic [NUM_MMIO*32-1:0] biu_i_mmio_rdata;

    modport slave (
        input  biu_i_iaddr, biu_i_dreq, biu_i_daddr, biu_i_dwmask, biu_i_dwdata,
               biu_i_itim_rdata, biu_i_dtim_rdata, biu_i_mmio_ack, biu_i_mmio_rdata,
        output biu_o_idata, biu_o_drdata, biu_o_halt, biu_o_derr, biu_o_itim_addr,
               biu_o_dtim_addr, biu_o_dtim_wmask, biu_o_dtim_wdata, biu_o_mmio_req,
               biu_o_mmio_addr, biu_o_mmio_wmask, biu_o_mmio_wdata
    );

    modport master (
        output biu_i_iaddr, biu_i_dreq, biu_i_daddr, biu_i_dwmask, biu_i_dwdata,
               biu_i_itim_rdata, biu_i_dtim_rdata, biu_i_mmio_ack, biu_i_mmio_rdata,
        input  biu_o_idata, biu_o_drdata, biu_o_halt, biu_o_derr, biu_o_itim_addr,
               biu_o_dtim_addr, biu_o_dtim_wmask, biu_o_dtim_wdata, biu_o_mmio_req,
               biu_o_mmio_addr, biu_o_mmio_wmask, biu_o_mmio_wdata
    );
endinterface

// File: rtl/biu_mmio_arb.sv
// biu_mmio_arb: decodes core fetch/data accesses onto ITIM, DTIM and req/ack MMIO channels with timeout
module biu_mmio_arb #(
    parameter int          DATA_W   = 32,
    parameter int          TIM_AW   = 12,
    parameter int          NUM_MMIO = 2,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input logic          clk,
    input logic          rst,
    biu_mmio_arb_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;

    logic [CW-1:0]       cnt;
    logic [3:0]          ch_q;
    logic [NUM_MMIO-1:0] req_q;
    logic [DATA_W-1:0]   resp_q;
    logic [31:0]         addr_q, wdata_q, rsel;
    logic [3:0]          wmask_q;
    logic                derr_q, dec_err_q, dtim_q, itim_q, nop_q;
    logic                d_dtim, d_mmio, d_err, dec_err, start, ack_hit, tmo;

    assign d_dtim  = bus.biu_i_daddr[31:28] == 4'h8;
    assign d_mmio  = bus.biu_i_daddr[31:28] == 4'h1 && 32'(bus.biu_i_daddr[27:24]) < NUM_MMIO;
    assign d_err   = !(bus.biu_i_daddr[31:28] == 4'h0 || d_dtim || d_mmio);
    assign dec_err = state == IDLE && bus.biu_i_dreq && d_err;
    assign start   = state == IDLE && bus.biu_i_dreq && d_mmio;
    // req_q is one-hot on the latched channel, so masking acks with it ignores other channels
    assign ack_hit = |(bus.biu_i_mmio_ack & req_q);
    assign tmo     = cnt == CW'(TIMEOUT - 1);

    always_comb begin
        rsel = '0;
        for (int k = 0; k < NUM_MMIO; k++)
            if (ch_q == 4'(k)) rsel = bus.biu_i_mmio_rdata[32*k +: 32];
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (start ? WAIT : IDLE) :
                   state == WAIT ? (ack_hit || tmo ? RESP : WAIT) : IDLE;

    always_comb
        bus.biu_o_halt = rst && (state == WAIT || start);

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            itim_q    <= 1'b0;
            nop_q     <= 1'b0;
            dtim_q    <= 1'b0;
            dec_err_q <= 1'b0;
            derr_q    <= 1'b0;
            req_q     <= '0;
            ch_q      <= '0;
            cnt       <= '0;
            addr_q    <= '0;
            wmask_q   <= '0;
            wdata_q   <= '0;
            resp_q    <= '0;
        end else begin
            itim_q    <= bus.biu_i_iaddr[31:28] == 4'h0;
            nop_q     <= bus.biu_i_iaddr[31:28] != 4'h0;
            dtim_q    <= bus.biu_i_dreq && d_dtim;
            dec_err_q <= dec_err;
            derr_q    <= dec_err || (state == WAIT && tmo && !ack_hit);
            if (start) begin
                addr_q  <= bus.biu_i_daddr;
                wmask_q <= bus.biu_i_dwmask;
                wdata_q <= bus.biu_i_dwdata;
                ch_q    <= bus.biu_i_daddr[27:24];
                req_q   <= NUM_MMIO'(1) << bus.biu_i_daddr[27:24];
                cnt     <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
                if (ack_hit || tmo) begin
                    req_q  <= '0;
                    resp_q <= ack_hit ? rsel : ERR_DATA;
                end
            end
        end

    assign bus.biu_o_idata      = itim_q ? bus.biu_i_itim_rdata : nop_q ? 32'h0000_0013 : 32'h0;
    assign bus.biu_o_drdata     = state == RESP ? resp_q : dec_err_q ? ERR_DATA :
                                  dtim_q ? bus.biu_i_dtim_rdata : 32'h0;
    assign bus.biu_o_derr       = derr_q;
    assign bus.biu_o_itim_addr  = bus.biu_i_iaddr[TIM_AW+1:2];
    assign bus.biu_o_dtim_addr  = bus.biu_i_daddr[TIM_AW+1:2];
    assign bus.biu_o_dtim_wmask = bus.biu_i_dreq && d_dtim ? bus.biu_i_dwmask : 4'h0;
    assign bus.biu_o_dtim_wdata = bus.biu_i_dwdata;
    assign bus.biu_o_mmio_req   = req_q;
    assign bus.biu_o_mmio_addr  = addr_q;
    assign bus.biu_o_mmio_wmask = wmask_q;
    assign bus.biu_o_mmio_wdata = wdata_q;
endmodule
